// File: rtl/move_list_reader_if.sv
// Child-position stream from the move list reader to the downstream evaluator/search.
interface move_list_reader_if #(
    parameter int BOARD_WIDTH = 256,
    parameter int IDX_W       = 6
);
    logic                   out_valid;
    logic                   out_ready;
    logic [BOARD_WIDTH-1:0] out_board;
    logic                   out_white_to_move;
    logic [3:0]             out_castle_mask;
    logic [3:0]             out_en_passant_col;
    logic [IDX_W-1:0]       out_index;
    logic                   out_last;

    modport master (
        output out_valid, out_board, out_white_to_move, out_castle_mask,
               out_en_passant_col, out_index, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_board, out_white_to_move, out_castle_mask,
               out_en_passant_col, out_index, out_last,
        output out_ready
    );
endinterface

// File: rtl/move_list_reader.sv
// Walks the move generator's position RAM (1-cycle registered read) and streams each
// child position out on a valid/ready interface, releasing the list when finished.
`ifndef PIECE_BITS
`define PIECE_BITS 4
`endif
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 64
`endif

module move_list_reader #(
    parameter int PIECE_WIDTH        = `PIECE_BITS,
    parameter int BOARD_WIDTH        = PIECE_WIDTH * 64,
    parameter int MAX_POSITIONS      = `MAX_POSITIONS,
    parameter int MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          moves_ready,
    input  logic [MAX_POSITIONS_LOG2-1:0] move_count,
    output logic [MAX_POSITIONS_LOG2-1:0] move_index,
    output logic                          clear_moves,
    input  logic [BOARD_WIDTH-1:0]        board_in,
    input  logic                          white_to_move_in,
    input  logic [3:0]                    castle_mask_in,
    input  logic [3:0]                    en_passant_col_in,
    output logic                          busy,
    output logic                          done,
    move_list_reader_if.master            out_s
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WAIT_READY = 3'd1;
    localparam logic [2:0] READ       = 3'd2;
    localparam logic [2:0] CAPTURE    = 3'd3;
    localparam logic [2:0] PRESENT    = 3'd4;
    localparam logic [2:0] CLEAR      = 3'd5;
    localparam logic [2:0] FLUSH      = 3'd6;

    localparam logic [MAX_POSITIONS_LOG2-1:0] IDX_ZERO = '0;
    localparam logic [MAX_POSITIONS_LOG2-1:0] IDX_ONE  = {{(MAX_POSITIONS_LOG2-1){1'b0}}, 1'b1};

    logic [2:0]                    state;
    logic                          flush_cnt;
    logic [MAX_POSITIONS_LOG2-1:0] cnt_r;

    logic                          out_valid_r;
    logic [BOARD_WIDTH-1:0]        out_board_r;
    logic                          out_wtm_r;
    logic [3:0]                    out_castle_r;
    logic [3:0]                    out_ep_r;
    logic [MAX_POSITIONS_LOG2-1:0] out_index_r;
    logic                          out_last_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            flush_cnt    <= 1'b0;
            cnt_r        <= IDX_ZERO;
            move_index   <= IDX_ZERO;
            out_valid_r  <= 1'b0;
            out_board_r  <= '0;
            out_wtm_r    <= 1'b0;
            out_castle_r <= 4'd0;
            out_ep_r     <= 4'd0;
            out_index_r  <= IDX_ZERO;
            out_last_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start)
                        state <= WAIT_READY;
                end
                WAIT_READY: begin
                    if (abort) begin
                        state <= CLEAR;
                    end else if (moves_ready) begin
                        cnt_r <= move_count;
                        if (move_count == IDX_ZERO) begin
                            state <= CLEAR;
                        end else begin
                            move_index <= IDX_ZERO;
                            state      <= READ;
                        end
                    end
                end
                // Address was registered by the generator last edge; data lands next cycle.
                READ: begin
                    state <= abort ? CLEAR : CAPTURE;
                end
                CAPTURE: begin
                    if (abort) begin
                        state <= CLEAR;
                    end else begin
                        out_board_r  <= board_in;
                        out_wtm_r    <= white_to_move_in;
                        out_castle_r <= castle_mask_in;
                        out_ep_r     <= en_passant_col_in;
                        out_index_r  <= move_index;
                        out_last_r   <= (move_index == cnt_r - IDX_ONE);
                        out_valid_r  <= 1'b1;
                        state        <= PRESENT;
                    end
                end
                // Abort wins over a same-cycle handshake: that transfer never happened.
                PRESENT: begin
                    if (abort) begin
                        out_valid_r <= 1'b0;
                        state       <= CLEAR;
                    end else if (out_s.out_ready) begin
                        out_valid_r <= 1'b0;
                        if (out_last_r) begin
                            state <= CLEAR;
                        end else begin
                            move_index <= move_index + IDX_ONE;
                            state      <= READ;
                        end
                    end
                end
                CLEAR: begin
                    flush_cnt <= 1'b0;
                    state     <= FLUSH;
                end
                // Give the generator time to drop its stale moves_ready.
                FLUSH: begin
                    flush_cnt <= 1'b1;
                    if (flush_cnt)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign clear_moves = (state == CLEAR);
    assign done        = (state == CLEAR);
    assign busy        = (state != IDLE);

    assign out_s.out_valid          = out_valid_r;
    assign out_s.out_board          = out_board_r;
    assign out_s.out_white_to_move  = out_wtm_r;
    assign out_s.out_castle_mask    = out_castle_r;
    assign out_s.out_en_passant_col = out_ep_r;
    assign out_s.out_index          = out_index_r;
    assign out_s.out_last           = out_last_r;
endmodule

// File: tb/tb_move_list_reader.sv
// Scoreboard bench for move_list_reader: a registered-read RAM model feeds the reader,
// expected children are queued at list setup and checked as they stream out.
module tb_move_list_reader;
    localparam int PW = 4;
    localparam int BW = PW * 64;
    localparam int MP = 64;
    localparam int L  = $clog2(MP);

    logic          clk = 1'b0;
    logic          reset, start, abort, moves_ready;
    logic [L-1:0]  move_count, move_index;
    logic          clear_moves, busy, done;
    logic [BW-1:0] board_in;
    logic          white_to_move_in;
    logic [3:0]    castle_mask_in, en_passant_col_in;

    move_list_reader_if #(.BOARD_WIDTH(BW), .IDX_W(L)) ifc ();

    move_list_reader #(.PIECE_WIDTH(PW), .BOARD_WIDTH(BW), .MAX_POSITIONS(MP),
                       .MAX_POSITIONS_LOG2(L)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .moves_ready(moves_ready), .move_count(move_count), .move_index(move_index),
        .clear_moves(clear_moves), .board_in(board_in),
        .white_to_move_in(white_to_move_in), .castle_mask_in(castle_mask_in),
        .en_passant_col_in(en_passant_col_in), .busy(busy), .done(done), .out_s(ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [L-1:0]  idx;
        logic          last;
        logic [BW-1:0] board;
        logic [8:0]    meta;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, seed = 0, rdy_pct = 100;
    int   n_xfer = 0, n_clear = 0, n_vcyc = 0, hs_cyc = 0, clr_cyc = 0;

    function automatic logic [BW-1:0] board_of(input int idx, input int s);
        logic [BW-1:0] b;
        for (int w = 0; w < BW / 32; w++)
            b[w*32 +: 32] = (s << 16) ^ (idx * 32'h0101_0101) ^ w;
        return b;
    endfunction

    function automatic logic [8:0] meta_of(input int idx, input int s);
        logic [31:0] i, k;
        i = idx;
        k = s;
        return {i[0] ^ k[0], i[3:0] ^ k[3:0], ~i[3:0]};
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Generator RAM: address registered on clk, data valid the following cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        board_in          <= board_of(int'(move_index), seed);
        {white_to_move_in, castle_mask_in, en_passant_col_in} <= meta_of(int'(move_index), seed);
    end

    logic          stall_q = 1'b0;
    logic [BW-1:0] snap_board;
    logic [15:0]   snap_meta;

    always @(negedge clk) begin
        if (reset) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", BW'(ifc.out_valid), BW'(1));
                chk("hold_board", ifc.out_board, snap_board);
                chk("hold_meta", BW'({ifc.out_index, ifc.out_last, ifc.out_white_to_move,
                                      ifc.out_castle_mask, ifc.out_en_passant_col}), BW'(snap_meta));
            end
            if (ifc.out_valid) n_vcyc++;
            if (clear_moves || done) begin
                chk("done_eq_clear", BW'(done), BW'(clear_moves));
                if (clear_moves) begin
                    n_clear++;
                    clr_cyc = cyc;
                end
            end
            if (ifc.out_valid && ifc.out_ready && !abort) begin
                chk("sb_nonempty", BW'(sb.size() != 0), BW'(1));
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_index", BW'(ifc.out_index), BW'(e.idx));
                    chk("out_last", BW'(ifc.out_last), BW'(e.last));
                    chk("out_board", ifc.out_board, e.board);
                    chk("out_meta", BW'({ifc.out_white_to_move, ifc.out_castle_mask,
                                         ifc.out_en_passant_col}), BW'(e.meta));
                end
                n_xfer++;
                hs_cyc = cyc;
            end
            stall_q    = ifc.out_valid && !ifc.out_ready && !abort;
            snap_board = ifc.out_board;
            snap_meta  = 16'({ifc.out_index, ifc.out_last, ifc.out_white_to_move,
                              ifc.out_castle_mask, ifc.out_en_passant_col});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        ifc.out_ready = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic load(input int cnt, input int s);
        move_count = L'(cnt);
        seed       = s;
        for (int i = 0; i < cnt; i++) begin
            exp_t e;
            e.idx   = L'(i);
            e.last  = (i == cnt - 1);
            e.board = board_of(i, s);
            e.meta  = meta_of(i, s);
            sb.push_back(e);
        end
    endtask

    task automatic begin_list(input int delay, output int rdy_cyc);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (delay) step();
        moves_ready = 1'b1;
        rdy_cyc = cyc;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            step();
            if (done) ok = 1'b1;
        end
        chk("done_seen", BW'(ok), BW'(1));
    endtask

    // Generator drops moves_ready one cycle after it sees clear_moves.
    task automatic release_list();
        step();
        moves_ready = 1'b0;
    endtask

    initial begin
        int  x0, c0, v0, rc;
        bit  hit;
        reset = 1'b1; start = 1'b0; abort = 1'b0; moves_ready = 1'b0;
        move_count = '0; ifc.out_ready = 1'b0;
        repeat (3) step();
        chk("rst_busy", BW'(busy), BW'(0));
        chk("rst_valid", BW'(ifc.out_valid), BW'(0));
        chk("rst_index", BW'(move_index), BW'(0));
        chk("rst_clear", BW'(clear_moves), BW'(0));
        chk("rst_out_index", BW'(ifc.out_index), BW'(0));
        reset = 1'b0;
        step();

        // basic walk
        x0 = n_xfer; c0 = n_clear; rdy_pct = 100;
        load(5, 'h11);
        begin_list(10, rc);
        wait_done();
        release_list();
        chk("walk_xfers", BW'(n_xfer - x0), BW'(5));
        chk("walk_clears", BW'(n_clear - c0), BW'(1));
        chk("walk_clr_lat", BW'(clr_cyc), BW'(hs_cyc + 1));
        chk("walk_sb_left", BW'(sb.size()), BW'(0));
        repeat (3) step();
        chk("walk_idle", BW'(busy), BW'(0));

        // backpressure
        x0 = n_xfer; c0 = n_clear; rdy_pct = 30;
        load(5, 'h22);
        begin_list(2, rc);
        wait_done();
        release_list();
        chk("bp_xfers", BW'(n_xfer - x0), BW'(5));
        chk("bp_clears", BW'(n_clear - c0), BW'(1));
        chk("bp_sb_left", BW'(sb.size()), BW'(0));
        repeat (3) step();

        // empty list
        x0 = n_xfer; c0 = n_clear; v0 = n_vcyc; rdy_pct = 100;
        load(0, 'h33);
        begin_list(3, rc);
        wait_done();
        release_list();
        chk("empty_vcyc", BW'(n_vcyc - v0), BW'(0));
        chk("empty_clears", BW'(n_clear - c0), BW'(1));
        chk("empty_clr_lat", BW'(clr_cyc), BW'(rc + 1));
        repeat (3) step();

        // abort in PRESENT at index 2 with out_ready high
        x0 = n_xfer; c0 = n_clear; hit = 1'b0;
        load(5, 'h44);
        begin_list(1, rc);
        for (int i = 0; i < 200 && !hit; i++) begin
            step();
            if (ifc.out_valid && ifc.out_index == L'(2) && ifc.out_ready) begin
                abort = 1'b1;
                hit   = 1'b1;
            end
        end
        chk("abort_hit", BW'(hit), BW'(1));
        step();
        abort = 1'b0;
        chk("abort_valid", BW'(ifc.out_valid), BW'(0));
        chk("abort_clear", BW'(clear_moves), BW'(1));
        release_list();
        chk("abort_flush1", BW'({busy, done}), BW'(2'b10));
        step();
        chk("abort_flush2", BW'({busy, done}), BW'(2'b10));
        step();
        chk("abort_idle", BW'(busy), BW'(0));
        chk("abort_xfers", BW'(n_xfer - x0), BW'(2));
        chk("abort_clears", BW'(n_clear - c0), BW'(1));
        chk("abort_sb_left", BW'(sb.size()), BW'(3));
        sb.delete();

        // reset mid-PRESENT at index 3
        c0 = n_clear; hit = 1'b0;
        load(6, 'h55);
        begin_list(1, rc);
        for (int i = 0; i < 200 && !hit; i++) begin
            step();
            if (ifc.out_valid && ifc.out_index == L'(3)) begin
                ifc.out_ready = 1'b0;
                reset = 1'b1;
                moves_ready = 1'b0;
                hit = 1'b1;
            end
        end
        chk("rst3_hit", BW'(hit), BW'(1));
        step();
        chk("rst3_valid", BW'(ifc.out_valid), BW'(0));
        chk("rst3_busy", BW'(busy), BW'(0));
        chk("rst3_index", BW'(move_index), BW'(0));
        reset = 1'b0;
        repeat (3) step();
        chk("rst3_no_clear", BW'(n_clear - c0), BW'(0));
        sb.delete();

        // restart: start held through CLEAR/FLUSH, stale moves_ready lingers one cycle
        x0 = n_xfer;
        load(3, 'h66);
        begin_list(2, rc);
        wait_done();
        start = 1'b1;
        release_list();
        chk("rs_flush1", BW'(busy), BW'(1));
        step();
        chk("rs_flush2", BW'(busy), BW'(1));
        step();
        chk("rs_idle", BW'(busy), BW'(0));
        step();
        chk("rs_wait", BW'(busy), BW'(1));
        start = 1'b0;
        chk("rs_first_xfers", BW'(n_xfer - x0), BW'(3));
        x0 = n_xfer; v0 = n_vcyc;
        load(4, 'h77);
        repeat (5) step();
        chk("rs_no_stale_read", BW'(n_vcyc - v0), BW'(0));
        chk("rs_still_waiting", BW'(busy), BW'(1));
        moves_ready = 1'b1;
        wait_done();
        release_list();
        chk("rs_second_xfers", BW'(n_xfer - x0), BW'(4));
        chk("rs_sb_left", BW'(sb.size()), BW'(0));
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
